pinaipple_bus_xbar: RTL and testbench
=====================================

// Module: pinaipple_bus_xbar
// PURPOSE
// Parametrised N-host x M-device data-bus crossbar for the PinAIpple SoC. Host side speaks
// Ibex LSU protocol (req/gnt/rvalid); device side uses the peripheral req/rvalid protocol
// (RAM, GPIO, UART, TIMER). Adds address decode, per-device round-robin arbitration,
// bounded outstanding requests with in-order response routing, and error responses for unmapped accesses.
// PARAMETERS
// NbrHosts        2             number of bus hosts (>=1)
// NbrDevices      4             number of devices (>=1)
// DataWidth       32            data bus width (multiple of 8)
// AddrWidth       32            host address width
// DevAddrWidth    12            device-local address width (low bits of host address)
// MaxOutstanding  2             max in-flight requests per device and per host (>=1)
// DevBase         see pkg       [NbrDevices][AddrWidth] base address per device
// DevMask         see pkg       [NbrDevices][AddrWidth] mask; hit = (addr & DevMask[d]) == DevBase[d]
// PORTS
// clk_i         in   1                       system clock
// rst_ni        in   1                       reset: one clock; synchronous, active-low
// host_req_i    in   [NbrHosts]              request, held until gnt
// host_gnt_o    out  [NbrHosts]              grant, same cycle as accepted req
// host_we_i     in   [NbrHosts]              write enable
// host_be_i     in   [NbrHosts][DataWidth/8] byte enables
// host_addr_i   in   [NbrHosts][AddrWidth]   byte address
// host_wdata_i  in   [NbrHosts][DataWidth]   write data
// host_rvalid_o out  [NbrHosts]              response valid (one per granted req)
// host_rdata_o  out  [NbrHosts][DataWidth]   read data; 0 when rvalid low
// host_err_o    out  [NbrHosts]              error, qualified by rvalid
// dev_req_o     out  [NbrDevices]            one-cycle request pulse
// dev_we_o/be_o/addr_o/wdata_o  out  per device  fields of granted host; addr = host_addr[DevAddrWidth-1:0]
// dev_rvalid_i  in   [NbrDevices]            device response, in order, >=1 cycle after req
// dev_rdata_i   in   [NbrDevices][DataWidth] read data
// dev_err_i     in   [NbrDevices]            device error, qualified by dev_rvalid_i
// BEHAVIOUR
// - Decode: combinational; lowest-index hit wins on overlap; no hit -> internal error target E.
// - Devices always accept: dev_req_o[d]=1 in the cycle host_gnt_o[h]=1 targeting d.
// - Arbitration per device: round-robin from ptr[d]; after grant to h, ptr[d]=(h+1)%NbrHosts.
// - Host h granted to target t only if: out_cnt[h]<MaxOutstanding AND (out_cnt[h]==0 OR
//   last_tgt[h]==t) AND (t==E OR dev FIFO[t] not full, or popping same cycle). Guarantees per-host in-order responses.
// - Per device: host-id FIFO depth MaxOutstanding; push on grant, pop on dev_rvalid_i;
//   simultaneous push/pop allowed (count unchanged). Pop routes rdata/err to host_*_o[head] same cycle (combinational).
// - Target E: grant immediately (subject to host rules); next cycle host_rvalid_o=1, err=1, rdata=0.
//   Back-to-back E requests respond every cycle.
// - out_cnt[h]: +1 on gnt, -1 on rvalid, both same cycle -> unchanged; never exceeds MaxOutstanding.
// - dev_rvalid_i with empty FIFO: dropped, no host response; sim assertion fires.
// - Unused dev_* fields driven 0 when dev_req_o low.
// - Reset: all outputs 0, FIFOs empty, out_cnt=0, ptr=0, pending E response cleared. Reset
//   mid-transaction drops in-flight requests; device responses arriving afterwards are dropped.
// - Width: host id width HostIdxW = NbrHosts==1 ? 1 : $clog2(NbrHosts); counters $clog2(MaxOutstanding+1).
// STRUCTURE
// - Package pinaipple_bus_pkg: default DevBase/DevMask for RAM 0x00100000/0xFFFF0000,
//   GPIO 0x80000000/0xFFFFF000, UART 0x80001000/0xFFFFF000, TIMER 0x80002000/0xFFFFF000;
//   bus_device_e enum; HostIdxW function.
// - Sub-module pinaipple_id_fifo: sync FIFO (Width, Depth), push/pop/full/empty/head,
//   one instance per device.
// TESTING (NbrHosts=2, NbrDevices=4, MaxOutstanding=2, pkg map)
// - H0 read 0x80000004 -> gnt[0] and dev_req_o[1] same cycle, dev_addr_o=0x004; dev_rvalid 0x000000A5
//   next cycle -> host_rvalid_o[0]=1, rdata=0xA5, err=0.
// - H0,H1 both read 0x00100010 in cycle 0 -> gnt H0 cyc0, H1 cyc1; repeat contention -> H1 first.
// - H1 write 0x40000000 -> gnt same cycle, no dev_req_o; next cycle rvalid[1]=1, err=1, rdata=0.
// - H0 read RAM (stub latency 3) then req GPIO -> gnt held low until RAM rvalid, GPIO granted
//   same cycle as that rvalid; responses arrive RAM then GPIO.
// - H0 3 back-to-back UART reads, UART delays rvalid -> 3rd gnt stalls until first dev_rvalid,
//   granted that cycle; out_cnt never >2.
// - Reset with 2 in flight -> all outputs 0 after edge; later dev_rvalid_i[0] -> no host_rvalid_o.

Source files
------------

// File: rtl/pinaipple_bus_xbar_pkg.sv
// rtl/pinaipple_bus_xbar_pkg.sv - shared types, default address map and helpers for the data-bus crossbar
// Contents:
//   bus_device_e      device index names for the default SoC map
//   DEV_BASE_DEFAULT  per-device base address (RAM, GPIO, UART, TIMER)
//   DEV_MASK_DEFAULT  per-device decode mask; hit = (addr & mask) == base
//   host_idx_w()      width of a host index (at least one bit)
package pinaipple_bus_pkg;

    typedef enum logic [1:0] {
        BUS_DEV_RAM   = 2'd0,
        BUS_DEV_GPIO  = 2'd1,
        BUS_DEV_UART  = 2'd2,
        BUS_DEV_TIMER = 2'd3
    } bus_device_e;

    localparam int unsigned DEFAULT_NBR_DEVICES = 4;

    // Element [0] is the rightmost entry of each concatenation.
    localparam logic [DEFAULT_NBR_DEVICES-1:0][31:0] DEV_BASE_DEFAULT = {
        32'h8000_2000,  // TIMER
        32'h8000_1000,  // UART
        32'h8000_0000,  // GPIO
        32'h0010_0000   // RAM
    };

    localparam logic [DEFAULT_NBR_DEVICES-1:0][31:0] DEV_MASK_DEFAULT = {
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hFFFF_0000
    };

    function automatic int unsigned host_idx_w(input int unsigned nbr_hosts);
        return (nbr_hosts == 1) ? 1 : $clog2(nbr_hosts);
    endfunction

endpackage

// File: rtl/pinaipple_bus_xbar_if.sv
// rtl/pinaipple_bus_xbar_if.sv - host/device bus bundle for the crossbar
// Signals keep the crossbar's point of view in their suffixes (_i into the crossbar, _o out of it).
//   host_*  : LSU-style req/gnt/rvalid per host
//   dev_*   : peripheral req/rvalid per device
// Modports:
//   slave   : the crossbar itself
//   master  : the surrounding hosts and devices
interface pinaipple_bus_xbar_if #(
    parameter int unsigned NbrHosts     = 2,
    parameter int unsigned NbrDevices   = 4,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DevAddrWidth = 12
);

    logic [NbrHosts-1:0]                        host_req_i;
    logic [NbrHosts-1:0]                        host_gnt_o;
    logic [NbrHosts-1:0]                        host_we_i;
    logic [NbrHosts-1:0][DataWidth/8-1:0]       host_be_i;
    logic [NbrHosts-1:0][AddrWidth-1:0]         host_addr_i;
    logic [NbrHosts-1:0][DataWidth-1:0]         host_wdata_i;
    logic [NbrHosts-1:0]                        host_rvalid_o;
    logic [NbrHosts-1:0][DataWidth-1:0]         host_rdata_o;
    logic [NbrHosts-1:0]                        host_err_o;

    logic [NbrDevices-1:0]                      dev_req_o;
    logic [NbrDevices-1:0]                      dev_we_o;
    logic [NbrDevices-1:0][DataWidth/8-1:0]     dev_be_o;
    logic [NbrDevices-1:0][DevAddrWidth-1:0]    dev_addr_o;
    logic [NbrDevices-1:0][DataWidth-1:0]       dev_wdata_o;
    logic [NbrDevices-1:0]                      dev_rvalid_i;
    logic [NbrDevices-1:0][DataWidth-1:0]       dev_rdata_i;
    logic [NbrDevices-1:0]                      dev_err_i;

    modport slave (
        input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
        input  dev_rvalid_i, dev_rdata_i, dev_err_i
    );

    modport master (
        output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o,
        output dev_rvalid_i, dev_rdata_i, dev_err_i
    );

endinterface

// File: rtl/pinaipple_id_fifo.sv
// rtl/pinaipple_id_fifo.sv - small synchronous FIFO holding host ids of in-flight device requests
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i  write an entry; accepted when not full, or when a pop happens the same cycle
//   pop_i          remove the head entry; ignored when empty
//   full_o/empty_o occupancy flags
//   head_o         current head entry (valid when not empty)
module pinaipple_id_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth == 1) ? 1 : $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0][Width-1:0] mem_q, mem_d;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        do_push;
    logic                        do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO may still take a push when its head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/pinaipple_bus_xbar.sv
// rtl/pinaipple_bus_xbar.sv - N-host x M-device data-bus crossbar with decode, round-robin arbitration and in-order responses
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset; drops everything in flight
//   bus     pinaipple_bus_xbar_if.slave: host req/gnt/rvalid side and device req/rvalid side
// Unmapped addresses go to an internal error target that answers one cycle after the grant.
module pinaipple_bus_xbar
    import pinaipple_bus_pkg::*;
#(
    parameter int unsigned NbrHosts       = 2,
    parameter int unsigned NbrDevices     = 4,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DevAddrWidth   = 12,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [NbrDevices-1:0][AddrWidth-1:0] DevBase = DEV_BASE_DEFAULT,
    parameter logic [NbrDevices-1:0][AddrWidth-1:0] DevMask = DEV_MASK_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pinaipple_bus_xbar_if.slave bus
);

    localparam int unsigned HostIdxW = host_idx_w(NbrHosts);
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned TgtW     = $clog2(NbrDevices + 1);
    // Targets 0..NbrDevices-1 are devices; index NbrDevices is the error target.
    localparam logic [TgtW-1:0] TgtErr = TgtW'(NbrDevices);

    logic [NbrHosts-1:0][TgtW-1:0]     tgt;
    logic [NbrDevices:0]               tgt_ready;
    logic [NbrHosts-1:0][CntW-1:0]     eff_cnt;
    logic [NbrHosts-1:0]               elig;
    logic [NbrHosts-1:0]               gnt;
    logic [NbrDevices-1:0]             dev_req;
    logic [NbrDevices-1:0][HostIdxW-1:0] win;
    logic [HostIdxW-1:0]               cand;

    logic [NbrHosts-1:0]               host_rvalid;
    logic [NbrHosts-1:0]               host_err;
    logic [NbrHosts-1:0][DataWidth-1:0] host_rdata;

    logic [NbrDevices-1:0]             fifo_pop;
    logic [NbrDevices-1:0]             fifo_full;
    logic [NbrDevices-1:0]             fifo_empty;
    logic [NbrDevices-1:0][HostIdxW-1:0] fifo_head;

    logic [NbrHosts-1:0][CntW-1:0]     out_cnt_q, out_cnt_d;
    logic [NbrHosts-1:0][TgtW-1:0]     last_tgt_q, last_tgt_d;
    logic [NbrHosts-1:0]               err_pend_q, err_pend_d;
    logic [NbrDevices-1:0][HostIdxW-1:0] ptr_q, ptr_d;

    // Address decode; scanning downwards lets the lowest-index hit win.
    always_comb begin
        tgt = '0;
        for (int h = 0; h < NbrHosts; h++) begin
            tgt[h] = TgtErr;
            for (int d = NbrDevices - 1; d >= 0; d--) begin
                if ((bus.host_addr_i[h] & DevMask[d]) == DevBase[d]) begin
                    tgt[h] = TgtW'(d);
                end
            end
        end
    end

    // Per-device id FIFOs remember which host each in-flight request belongs to.
    for (genvar d = 0; d < NbrDevices; d++) begin : g_dev
        assign fifo_pop[d] = bus.dev_rvalid_i[d] & ~fifo_empty[d];

        pinaipple_id_fifo #(
            .Width (HostIdxW),
            .Depth (MaxOutstanding)
        ) u_id_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (dev_req[d]),
            .data_i  (win[d]),
            .pop_i   (fifo_pop[d]),
            .full_o  (fifo_full[d]),
            .empty_o (fifo_empty[d]),
            .head_o  (fifo_head[d])
        );

        always_ff @(posedge clk_i) begin
            if (rst_ni && bus.dev_rvalid_i[d]) begin
                assert (!fifo_empty[d])
                    else $warning("device %0d response with no outstanding request dropped", d);
            end
        end
    end

    // Response routing: device responses go to the host at the FIFO head, error-target
    // responses come from the per-host pending flag.
    always_comb begin
        host_rvalid = '0;
        host_err    = '0;
        host_rdata  = '0;
        for (int h = 0; h < NbrHosts; h++) begin
            if (err_pend_q[h]) begin
                host_rvalid[h] = 1'b1;
                host_err[h]    = 1'b1;
            end
        end
        for (int d = 0; d < NbrDevices; d++) begin
            if (fifo_pop[d]) begin
                host_rvalid[fifo_head[d]] = 1'b1;
                host_err[fifo_head[d]]    = host_err[fifo_head[d]] | bus.dev_err_i[d];
                host_rdata[fifo_head[d]]  = host_rdata[fifo_head[d]] | bus.dev_rdata_i[d];
            end
        end
    end

    // A target can take a request when its FIFO has room or is draining this cycle.
    always_comb begin
        tgt_ready = '0;
        for (int d = 0; d < NbrDevices; d++) begin
            tgt_ready[d] = ~fifo_full[d] | bus.dev_rvalid_i[d];
        end
        tgt_ready[NbrDevices] = 1'b1;
    end

    // Host eligibility. The outstanding count is taken net of a response retiring this
    // cycle, so a host may be granted (and may switch target) in the same cycle its
    // last response returns. Switching target only with nothing outstanding keeps
    // every host's responses in request order.
    always_comb begin
        eff_cnt = '0;
        elig    = '0;
        for (int h = 0; h < NbrHosts; h++) begin
            eff_cnt[h] = out_cnt_q[h] - CntW'(host_rvalid[h]);
            elig[h]    = bus.host_req_i[h]
                       && (eff_cnt[h] < CntW'(MaxOutstanding))
                       && ((eff_cnt[h] == '0) || (last_tgt_q[h] == tgt[h]))
                       && tgt_ready[tgt[h]];
        end
    end

    // Round-robin per device starting at ptr_q; the error target needs no arbitration.
    always_comb begin
        gnt     = '0;
        dev_req = '0;
        win     = '0;
        ptr_d   = ptr_q;
        cand    = '0;
        for (int h = 0; h < NbrHosts; h++) begin
            if (elig[h] && (tgt[h] == TgtErr)) begin
                gnt[h] = 1'b1;
            end
        end
        for (int d = 0; d < NbrDevices; d++) begin
            cand = ptr_q[d];
            for (int i = 0; i < NbrHosts; i++) begin
                if (!dev_req[d] && elig[cand] && (tgt[cand] == TgtW'(d))) begin
                    dev_req[d] = 1'b1;
                    win[d]     = cand;
                    gnt[cand]  = 1'b1;
                end
                cand = (cand == HostIdxW'(NbrHosts - 1)) ? '0 : cand + 1'b1;
            end
            if (dev_req[d]) begin
                ptr_d[d] = (win[d] == HostIdxW'(NbrHosts - 1)) ? '0 : win[d] + 1'b1;
            end
        end
    end

    always_comb begin
        out_cnt_d  = out_cnt_q;
        last_tgt_d = last_tgt_q;
        err_pend_d = '0;
        for (int h = 0; h < NbrHosts; h++) begin
            out_cnt_d[h] = out_cnt_q[h] + CntW'(gnt[h]) - CntW'(host_rvalid[h]);
            if (gnt[h]) begin
                last_tgt_d[h] = tgt[h];
                err_pend_d[h] = (tgt[h] == TgtErr);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q  <= '0;
            last_tgt_q <= '0;
            err_pend_q <= '0;
            ptr_q      <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            last_tgt_q <= last_tgt_d;
            err_pend_q <= err_pend_d;
            ptr_q      <= ptr_d;
        end
    end

    // Device-side fields follow the granted host and are zero when no request is issued.
    always_comb begin
        bus.dev_we_o    = '0;
        bus.dev_be_o    = '0;
        bus.dev_addr_o  = '0;
        bus.dev_wdata_o = '0;
        for (int d = 0; d < NbrDevices; d++) begin
            if (dev_req[d]) begin
                bus.dev_we_o[d]    = bus.host_we_i[win[d]];
                bus.dev_be_o[d]    = bus.host_be_i[win[d]];
                bus.dev_addr_o[d]  = bus.host_addr_i[win[d]][DevAddrWidth-1:0];
                bus.dev_wdata_o[d] = bus.host_wdata_i[win[d]];
            end
        end
    end

    assign bus.dev_req_o     = dev_req;
    assign bus.host_gnt_o    = gnt;
    assign bus.host_rvalid_o = host_rvalid;
    assign bus.host_err_o    = host_err;
    assign bus.host_rdata_o  = host_rdata;

endmodule

// File: tb/tb_pinaipple_bus_xbar.sv
// tb/tb_pinaipple_bus_xbar.sv - directed vector bench for the data-bus crossbar
module tb_pinaipple_bus_xbar;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    pinaipple_bus_xbar_if #(
        .NbrHosts(2), .NbrDevices(4), .DataWidth(32), .AddrWidth(32), .DevAddrWidth(12)
    ) bus_if ();

    pinaipple_bus_xbar #(
        .NbrHosts(2), .NbrDevices(4), .DataWidth(32), .AddrWidth(32),
        .DevAddrWidth(12), .MaxOutstanding(2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  drv;
        logic [3:0]  derr;
        logic [31:0] drd;
        logic [1:0]  gnt;
        logic [3:0]  dreq;
        logic [1:0]  rv;
        logic [1:0]  err;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [11:0] da1;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] RAM  = 32'h0010_0010;
    localparam logic [31:0] GPIO = 32'h8000_0004;
    localparam logic [31:0] UART = 32'h8001_0000 - 32'h0000_F000 + 32'h8;  // 0x80001008
    localparam logic [31:0] BAD  = 32'h4000_0000;

    function automatic vec_t mk(
        input string n, input logic r, input logic [1:0] req, input logic [1:0] we,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [3:0] drv, input logic [3:0] derr, input logic [31:0] drd,
        input logic [1:0] gnt, input logic [3:0] dreq, input logic [1:0] rv,
        input logic [1:0] err, input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [11:0] da1);
        vec_t v;
        v.name = n; v.rst_n = r; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
        v.drv = drv; v.derr = derr; v.drd = drd; v.gnt = gnt; v.dreq = dreq;
        v.rv = rv; v.err = err; v.rd0 = rd0; v.rd1 = rd1; v.da1 = da1;
        return v;
    endfunction

    task automatic chk(input string vn, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %h, expected %h", vn, f, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.host_req_i   = '0;
        bus_if.host_we_i    = '0;
        bus_if.host_be_i    = {4'hF, 4'hF};
        bus_if.host_addr_i  = '0;
        bus_if.host_wdata_i = '0;
        bus_if.dev_rvalid_i = '0;
        bus_if.dev_rdata_i  = '0;
        bus_if.dev_err_i    = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n                  = v.rst_n;
        bus_if.host_req_i      = v.req;
        bus_if.host_we_i       = v.we;
        bus_if.host_addr_i[0]  = v.a0;
        bus_if.host_addr_i[1]  = v.a1;
        bus_if.dev_rvalid_i    = v.drv;
        bus_if.dev_err_i       = v.derr;
        for (int d = 0; d < 4; d++) bus_if.dev_rdata_i[d] = v.drd;
        #2;
        n_vec++;
        chk(v.name, "gnt",    32'(bus_if.host_gnt_o),    32'(v.gnt));
        chk(v.name, "dreq",   32'(bus_if.dev_req_o),     32'(v.dreq));
        chk(v.name, "rvalid", 32'(bus_if.host_rvalid_o), 32'(v.rv));
        chk(v.name, "err",    32'(bus_if.host_err_o),    32'(v.err));
        chk(v.name, "rdata0", bus_if.host_rdata_o[0],    v.rd0);
        chk(v.name, "rdata1", bus_if.host_rdata_o[1],    v.rd1);
        chk(v.name, "daddr1", 32'(bus_if.dev_addr_o[1]), 32'(v.da1));
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        //          name                 rst req   we    a0            a1    drv    derr   drd           gnt   dreq   rv    err   rd0           rd1    da1
        vecs.push_back(mk("reset",        0, 2'b00, 2'b00, 0,           0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("idle",         1, 2'b00, 2'b00, 0,           0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("a_gpio_req",   1, 2'b01, 2'b00, GPIO,        0,    4'h0, 4'h0, 0,            2'b01, 4'h2, 2'b00, 2'b00, 0,           0,     12'h004));
        vecs.push_back(mk("a_gpio_rsp",   1, 2'b00, 2'b00, 0,           0,    4'h2, 4'h0, 32'hA5,       2'b00, 4'h0, 2'b01, 2'b00, 32'hA5,      0,     12'h0));
        vecs.push_back(mk("b_both",       1, 2'b11, 2'b00, RAM,         RAM,  4'h0, 4'h0, 0,            2'b01, 4'h1, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("b_rr_h1",      1, 2'b11, 2'b00, RAM,         RAM,  4'h0, 4'h0, 0,            2'b10, 4'h1, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("b_full_pop",   1, 2'b11, 2'b00, RAM,         RAM,  4'h1, 4'h0, 32'h11,       2'b01, 4'h1, 2'b01, 2'b00, 32'h11,      0,     12'h0));
        vecs.push_back(mk("b_h1_pop",     1, 2'b10, 2'b00, RAM,         RAM,  4'h1, 4'h0, 32'h22,       2'b10, 4'h1, 2'b10, 2'b00, 0,           32'h22, 12'h0));
        vecs.push_back(mk("b_rsp_h0",     1, 2'b00, 2'b00, 0,           0,    4'h1, 4'h0, 32'h33,       2'b00, 4'h0, 2'b01, 2'b00, 32'h33,      0,     12'h0));
        vecs.push_back(mk("b_rsp_h1",     1, 2'b00, 2'b00, 0,           0,    4'h1, 4'h0, 32'h44,       2'b00, 4'h0, 2'b10, 2'b00, 0,           32'h44, 12'h0));
        vecs.push_back(mk("c_err_wr",     1, 2'b10, 2'b10, 0,           BAD,  4'h0, 4'h0, 0,            2'b10, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("c_err_rsp",    1, 2'b00, 2'b00, 0,           0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b10, 2'b10, 0,           0,     12'h0));
        vecs.push_back(mk("c_e0_1",       1, 2'b01, 2'b00, BAD,         0,    4'h0, 4'h0, 0,            2'b01, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("c_e0_2",       1, 2'b01, 2'b00, BAD,         0,    4'h0, 4'h0, 0,            2'b01, 4'h0, 2'b01, 2'b01, 0,           0,     12'h0));
        vecs.push_back(mk("c_e0_rsp",     1, 2'b00, 2'b00, 0,           0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b01, 2'b01, 0,           0,     12'h0));
        vecs.push_back(mk("d_ram",        1, 2'b01, 2'b00, 32'h00100000, 0,   4'h0, 4'h0, 0,            2'b01, 4'h1, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("d_gpio_wait1", 1, 2'b01, 2'b00, 32'h80000000, 0,   4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("d_gpio_wait2", 1, 2'b01, 2'b00, 32'h80000000, 0,   4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("d_ram_rsp_gnt",1, 2'b01, 2'b00, 32'h80000000, 0,   4'h1, 4'h0, 32'h55,       2'b01, 4'h2, 2'b01, 2'b00, 32'h55,      0,     12'h000));
        vecs.push_back(mk("d_gpio_rsp",   1, 2'b00, 2'b00, 0,           0,    4'h2, 4'h0, 32'h66,       2'b00, 4'h0, 2'b01, 2'b00, 32'h66,      0,     12'h0));
        vecs.push_back(mk("e_uart1",      1, 2'b01, 2'b00, UART,        0,    4'h0, 4'h0, 0,            2'b01, 4'h4, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("e_uart2",      1, 2'b01, 2'b00, UART,        0,    4'h0, 4'h0, 0,            2'b01, 4'h4, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("e_stall1",     1, 2'b01, 2'b00, UART,        0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("e_stall2",     1, 2'b01, 2'b00, UART,        0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("e_uart3_gnt",  1, 2'b01, 2'b00, UART,        0,    4'h4, 4'h0, 32'h77,       2'b01, 4'h4, 2'b01, 2'b00, 32'h77,      0,     12'h0));
        vecs.push_back(mk("e_rsp2",       1, 2'b00, 2'b00, 0,           0,    4'h4, 4'h0, 32'h88,       2'b00, 4'h0, 2'b01, 2'b00, 32'h88,      0,     12'h0));
        vecs.push_back(mk("e_rsp3_err",   1, 2'b00, 2'b00, 0,           0,    4'h4, 4'h4, 32'h99,       2'b00, 4'h0, 2'b01, 2'b01, 32'h99,      0,     12'h0));
        vecs.push_back(mk("r_two",        1, 2'b11, 2'b00, 32'h80001000, 32'h00100000, 4'h0, 4'h0, 0, 2'b11, 4'h5, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("r_three",      1, 2'b01, 2'b00, 32'h80001000, 0,   4'h0, 4'h0, 0,            2'b01, 4'h4, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("r_reset",      0, 2'b00, 2'b00, 0,           0,    4'h0, 4'h0, 0,            2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("r_stale_rsp",  1, 2'b00, 2'b00, 0,           0,    4'h5, 4'h0, 32'hDEAD,     2'b00, 4'h0, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("r_uart",       1, 2'b01, 2'b00, 32'h80001000, 0,   4'h0, 4'h0, 0,            2'b01, 4'h4, 2'b00, 2'b00, 0,           0,     12'h0));
        vecs.push_back(mk("r_uart_rsp",   1, 2'b00, 2'b00, 0,           0,    4'h4, 4'h0, 32'h12,       2'b00, 4'h0, 2'b01, 2'b00, 32'h12,      0,     12'h0));

        foreach (vecs[i]) apply(vecs[i]);

        // Write to GPIO: granted host's fields appear on device 1, idle devices stay zero.
        @(negedge clk);
        drive_idle();
        bus_if.host_req_i      = 2'b01;
        bus_if.host_we_i       = 2'b01;
        bus_if.host_addr_i[0]  = 32'h8000_0ABC;
        bus_if.host_wdata_i[0] = 32'hCAFE_F00D;
        bus_if.host_be_i[0]    = 4'b0011;
        #2;
        n_vec++;
        chk("w_fields", "gnt",    32'(bus_if.host_gnt_o),     32'h1);
        chk("w_fields", "dreq",   32'(bus_if.dev_req_o),      32'h2);
        chk("w_fields", "we",     32'(bus_if.dev_we_o),       32'h2);
        chk("w_fields", "be1",    32'(bus_if.dev_be_o[1]),    32'h3);
        chk("w_fields", "addr1",  32'(bus_if.dev_addr_o[1]),  32'hABC);
        chk("w_fields", "wdata1", bus_if.dev_wdata_o[1],      32'hCAFE_F00D);
        chk("w_fields", "wdata0", bus_if.dev_wdata_o[0],      32'h0);
        chk("w_fields", "be0",    32'(bus_if.dev_be_o[0]),    32'h0);
        @(negedge clk);
        drive_idle();
        bus_if.dev_rvalid_i = 4'h2;
        #2;
        n_vec++;
        chk("w_rsp", "rvalid", 32'(bus_if.host_rvalid_o), 32'h1);
        chk("w_rsp", "err",    32'(bus_if.host_err_o),    32'h0);

        // A pending error response is discarded by reset.
        @(negedge clk);
        drive_idle();
        bus_if.host_req_i     = 2'b10;
        bus_if.host_addr_i[1] = BAD;
        #2;
        n_vec++;
        chk("er_gnt", "gnt", 32'(bus_if.host_gnt_o), 32'h2);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #2;
        n_vec++;
        chk("er_in_reset", "rvalid", 32'(bus_if.host_rvalid_o), 32'h2);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_vec++;
        chk("er_after_reset", "rvalid", 32'(bus_if.host_rvalid_o), 32'h0);
        chk("er_after_reset", "err",    32'(bus_if.host_err_o),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
